// File: rtl/stack_pkg.sv
// stack_pkg: command encodings and count-width helper for stack_param
package stack_pkg;
  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_CLEAR   = 3'b001;
  localparam logic [2:0] CMD_PUSH    = 3'b010;
  localparam logic [2:0] CMD_POP     = 3'b011;
  localparam logic [2:0] CMD_REPLACE = 3'b100;
  localparam logic [2:0] CMD_PEEK    = 3'b101;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stack_param.sv
// stack_param: parametrised LIFO with count, top view, replace/peek and error strobe
module stack_param
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             error
);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             push_ok, rd_ok, pop_ok, rep_ok, legal, we;
  logic [AW-1:0]    taddr, waddr;
  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;
  assign taddr     = AW'(count_q - CW'(1));
  assign count     = count_q;
  assign data_out  = dout_q;
  assign out_valid = valid_q;
  assign error     = err_q;
  always_comb begin
    push_ok = cmd == CMD_PUSH && !full;
    pop_ok  = cmd == CMD_POP && !empty;
    rep_ok  = cmd == CMD_REPLACE && !empty;
    rd_ok   = pop_ok || rep_ok || (cmd == CMD_PEEK && !empty);
    legal   = cmd == CMD_NOP || cmd == CMD_CLEAR || push_ok || rd_ok;
    // a command presented together with reset must not touch storage
    we      = (push_ok || rep_ok) && !rst;
    waddr   = push_ok ? AW'(count_q) : taddr;
    count_d = cmd == CMD_CLEAR ? '0 : push_ok ? count_q + CW'(1) : pop_ok ? count_q - CW'(1) : count_q;
    dout_d  = rd_ok ? top : dout_q;
    valid_d = rd_ok;
    err_d   = !legal;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (data_in),
    .raddr_i (taddr),
    .rdata_o (top)
  );
endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param: drives an 8x8 and a 16x2 stack with one command stream against a stack model
module tb_stack_param;
  localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, PSH = 3'd2, POP = 3'd3, REP = 3'd4, PEK = 3'd5;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [7:0] din_a = '0, dout_a, top_a;
  logic [15:0] din_b = '0, dout_b, top_b;
  logic [3:0] count_a;
  logic [1:0] count_b;
  logic va, fa, ea, ra, vb, fb, eb, rb;
  int errors = 0, checks = 0;
  logic live = 1'b0;
  logic [15:0] mm [2][8];
  int mc [2];
  logic [15:0] md [2];
  logic mv [2], me [2];
  int dep [2] = '{8, 2};
  always #5 clk = ~clk;
  stack_param #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .cmd(cmd), .data_in(din_a), .data_out(dout_a), .out_valid(va),
    .top(top_a), .count(count_a), .full(fa), .empty(ea), .error(ra));
  stack_param #(.WIDTH(16), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .cmd(cmd), .data_in(din_b), .data_out(dout_b), .out_valid(vb),
    .top(top_b), .count(count_b), .full(fb), .empty(eb), .error(rb));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic op(input logic [2:0] c, input logic [7:0] d, input logic r = 1'b0);
    logic [15:0] w, v;
    w = {~d, d};
    @(negedge clk);
    rst = r; cmd = c; din_a = d; din_b = w;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      v = k == 0 ? {8'h00, d} : w;
      mv[k] = 1'b0; me[k] = 1'b0;
      if (r) begin
        mc[k] = 0; md[k] = '0;
      end else if (c == NOP) begin
      end else if (c == CLR) mc[k] = 0;
      else if (c == PSH) begin
        if (mc[k] == dep[k]) me[k] = 1'b1;
        else begin mm[k][mc[k]] = v; mc[k]++; end
      end else if (c == POP || c == REP || c == PEK) begin
        if (mc[k] == 0) me[k] = 1'b1;
        else begin
          md[k] = mm[k][mc[k]-1]; mv[k] = 1'b1;
          if (c == POP) mc[k]--;
          if (c == REP) mm[k][mc[k]-1] = v;
        end
      end else me[k] = 1'b1;
    end
    if (r) live = 1'b1;
    #1;
  endtask
  always @(negedge clk) if (live) begin
    chk("a_count", count_a, mc[0]);
    chk("a_full", fa, mc[0] == 8);
    chk("a_empty", ea, mc[0] == 0);
    chk("a_dout", dout_a, md[0]);
    chk("a_valid", va, mv[0]);
    chk("a_error", ra, me[0]);
    if (mc[0] > 0) chk("a_top", top_a, mm[0][mc[0]-1]);
    chk("b_count", count_b, mc[1]);
    chk("b_full", fb, mc[1] == 2);
    chk("b_empty", eb, mc[1] == 0);
    chk("b_dout", dout_b, md[1]);
    chk("b_valid", vb, mv[1]);
    chk("b_error", rb, me[1]);
    if (mc[1] > 0) chk("b_top", top_b, mm[1][mc[1]-1]);
  end
  initial begin
    op(NOP, 8'h00, 1'b1);
    chk("rst_count", count_a, 0); chk("rst_empty", ea, 1); chk("rst_dout", dout_a, 0);
    op(PSH, 8'h11); op(PSH, 8'h22); op(PSH, 8'h33);
    chk("p3_count", count_a, 3); chk("p3_top", top_a, 8'h33); chk("p3_empty", ea, 0);
    chk("b_full2", fb, 1); chk("b_err3", rb, 1); chk("b_cnt2", count_b, 2);
    op(POP, 8'h00); chk("pop1", dout_a, 8'h33); chk("pop1_v", va, 1); chk("b_pop1", dout_b, 16'hDD22);
    op(POP, 8'h00); chk("pop2", dout_a, 8'h22); chk("b_pop2", dout_b, 16'hEE11);
    op(POP, 8'h00); chk("pop3", dout_a, 8'h11); chk("pop3_v", va, 1);
    chk("pop3_cnt", count_a, 0); chk("pop3_empty", ea, 1); chk("b_pop3_err", rb, 1);
    for (int i = 0; i < 8; i++) op(PSH, 8'hA0 + 8'(i));
    chk("fill_full", fa, 1); chk("fill_cnt", count_a, 8); chk("b_fill_top", top_b, 16'h5EA1);
    op(PSH, 8'hFF);
    chk("ovf_err", ra, 1); chk("ovf_cnt", count_a, 8); chk("ovf_top", top_a, 8'hA7);
    op(NOP, 8'h00); chk("ovf_err_clr", ra, 0);
    op(CLR, 8'h00);
    op(POP, 8'h00); chk("e_pop_err", ra, 1); chk("e_pop_v", va, 0); chk("e_pop_d", dout_a, 8'h11);
    op(PEK, 8'h00); chk("e_peek_err", ra, 1);
    op(REP, 8'h42); chk("e_rep_err", ra, 1); chk("e_rep_cnt", count_a, 0);
    op(3'd6, 8'h00); chk("rsv_err", ra, 1); chk("rsv_d", dout_a, 8'h11);
    op(PSH, 8'h05); op(PSH, 8'h07);
    op(REP, 8'h09); chk("rep_d", dout_a, 8'h07); chk("rep_top", top_a, 8'h09);
    chk("rep_cnt", count_a, 2); chk("b_rep_d", dout_b, 16'hF807);
    op(PEK, 8'h00); chk("peek_d", dout_a, 8'h09); chk("peek_cnt", count_a, 2);
    for (int i = 0; i < 6; i++) op(PSH, 8'h40 + 8'(i));
    op(REP, 8'h5A); chk("frep_err", ra, 0); chk("frep_v", va, 1); chk("frep_d", dout_a, 8'h45);
    chk("frep_top", top_a, 8'h5A); chk("b_frep_d", dout_b, 16'hF609);
    op(CLR, 8'h00);
    for (int i = 0; i < 5; i++) op(PSH, 8'h60 + 8'(i));
    op(PSH, 8'h77, 1'b1);
    chk("rp_cnt", count_a, 0); chk("rp_empty", ea, 1); chk("rp_v", va, 0); chk("rp_err", ra, 0);
    op(POP, 8'h00); chk("rp_pop_err", ra, 1);
    op(PSH, 8'h01); op(PSH, 8'h02);
    op(CLR, 8'h00); chk("clr_cnt", count_a, 0); chk("clr_err", ra, 0);
    op(NOP, 8'h00);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
